// File: rtl/sd_sector_server.sv
// Responder side of the virtual-disk sector interface: arbitrates sd_rd/sd_wr requests
// and streams one 512-byte sector per grant between the initiator buffer and a backing store.
module sd_sector_server #(
  parameter int VDNUM = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [VDNUM*32-1:0]  sd_lba,
  input  logic [VDNUM-1:0]     sd_rd,
  input  logic [VDNUM-1:0]     sd_wr,
  output logic [VDNUM-1:0]     sd_ack,
  input  logic [VDNUM-1:0]     dev_mounted,
  output logic [8:0]           sd_buff_addr,
  output logic [7:0]           sd_buff_dout,
  input  logic [VDNUM*8-1:0]   sd_buff_din,
  output logic                 sd_buff_wr,
  output logic [31:0]          mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ready
);

  localparam int DW = (VDNUM > 1) ? $clog2(VDNUM) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_FETCH, RD_PUSH, WR_ADDR, WR_WAIT, WR_STORE, GAP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dev_q, dev_d;
  logic [DW-1:0]   rr_q, rr_d;
  logic [22:0]     lba_q, lba_d;
  logic            mounted_q, mounted_d;
  logic [8:0]      i_q, i_d;
  logic [VDNUM-1:0] ack_q, ack_d;
  logic [8:0]      buff_addr_q, buff_addr_d;
  logic [7:0]      buff_dout_q, buff_dout_d;
  logic            buff_wr_q, buff_wr_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;

  logic [VDNUM-1:0] req;
  logic             found;
  logic [DW-1:0]    sel;
  logic             sel_rd;
  logic             sel_mounted;
  logic [22:0]      sel_lba;
  logic [7:0]       din_sel;
  logic             try_grant;
  logic             last_byte;
  logic             unused_lba_bits;

  // Round-robin search starts at rr_q, the index after the last device served.
  always_comb begin
    req             = sd_rd | sd_wr;
    found           = 1'b0;
    sel             = '0;
    sel_rd          = 1'b0;
    sel_mounted     = 1'b0;
    sel_lba         = '0;
    din_sel         = '0;
    unused_lba_bits = 1'b0;
    for (int k = 0; k < VDNUM; k++) begin
      for (int n = 0; n < VDNUM; n++) begin
        if (!found && req[n] && (n == (int'(rr_q) + k) % VDNUM)) begin
          found = 1'b1;
          sel   = DW'(n);
        end
      end
    end
    for (int n = 0; n < VDNUM; n++) begin
      if (sel == DW'(n)) begin
        sel_rd      = sd_rd[n];
        sel_mounted = dev_mounted[n];
        sel_lba     = sd_lba[32*n +: 23];
      end
      if (dev_q == DW'(n)) begin
        din_sel = sd_buff_din[8*n +: 8];
      end
      unused_lba_bits = unused_lba_bits ^ (^sd_lba[32*n+23 +: 9]);
    end
  end

  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    rr_d        = rr_q;
    lba_d       = lba_q;
    mounted_d   = mounted_q;
    i_d         = i_q;
    ack_d       = ack_q;
    buff_addr_d = buff_addr_q;
    buff_dout_d = buff_dout_q;
    buff_wr_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    try_grant   = 1'b0;
    last_byte   = (i_q == 9'd511);

    case (state_q)
      IDLE: try_grant = 1'b1;
      RD_FETCH: begin
        // An unmounted device completes at once with zero data and no memory request.
        if (!mounted_q || mem_ready) begin
          mem_rd_d    = 1'b0;
          buff_wr_d   = 1'b1;
          buff_addr_d = i_q;
          buff_dout_d = mounted_q ? mem_rdata : 8'h00;
          state_d     = RD_PUSH;
        end
      end
      RD_PUSH: begin
        i_d = i_q + 9'd1;
        if (last_byte) begin
          ack_d   = '0;
          state_d = GAP;
        end else begin
          mem_rd_d   = mounted_q;
          mem_addr_d = {lba_q, i_q + 9'd1};
          state_d    = RD_FETCH;
        end
      end
      WR_ADDR: state_d = WR_WAIT;
      WR_WAIT: begin
        mem_wdata_d = din_sel;
        mem_addr_d  = {lba_q, i_q};
        mem_wr_d    = mounted_q;
        state_d     = WR_STORE;
      end
      WR_STORE: begin
        if (!mounted_q || mem_ready) begin
          mem_wr_d = 1'b0;
          i_d      = i_q + 9'd1;
          if (last_byte) begin
            ack_d   = '0;
            state_d = GAP;
          end else begin
            buff_addr_d = i_q + 9'd1;
            state_d     = WR_ADDR;
          end
        end
      end
      GAP: begin
        // Ack is already low here; a still-held request is re-granted on the way back to IDLE.
        state_d   = IDLE;
        try_grant = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (try_grant && found) begin
      dev_d     = sel;
      rr_d      = DW'((int'(sel) + 1) % VDNUM);
      lba_d     = sel_lba;
      mounted_d = sel_mounted;
      i_d       = '0;
      for (int n = 0; n < VDNUM; n++) begin
        ack_d[n] = (sel == DW'(n));
      end
      if (sel_rd) begin
        mem_rd_d   = sel_mounted;
        mem_addr_d = {sel_lba, 9'd0};
        state_d    = RD_FETCH;
      end else begin
        buff_addr_d = '0;
        state_d     = WR_ADDR;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dev_q       <= '0;
      rr_q        <= '0;
      lba_q       <= '0;
      mounted_q   <= 1'b0;
      i_q         <= '0;
      ack_q       <= '0;
      buff_addr_q <= '0;
      buff_dout_q <= '0;
      buff_wr_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dev_q       <= dev_d;
      rr_q        <= rr_d;
      lba_q       <= lba_d;
      mounted_q   <= mounted_d;
      i_q         <= i_d;
      ack_q       <= ack_d;
      buff_addr_q <= buff_addr_d;
      buff_dout_q <= buff_dout_d;
      buff_wr_q   <= buff_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = buff_addr_q;
  assign sd_buff_dout = buff_dout_q;
  assign sd_buff_wr   = buff_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
